// File: rtl/ckp_gen.sv
// ckp_gen: 60-2 crank wheel (cap) and cam phase generator for HIL stimulus.
// Optional feature macro: CKP_GEN_CAM_EN builds the cam toggle flop.
module ckp_gen #(
    parameter int TOOTH_TOTAL   = 60,
    parameter int TOOTH_MISSING = 2,
    parameter int PERIOD_WIDTH  = 24,
    parameter int TCNT_WIDTH    = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic [PERIOD_WIDTH-1:0] period,
    output logic                    cap,
    output logic                    cam,
    output logic [TCNT_WIDTH-1:0]   tooth,
    output logic                    rev_strobe,
    output logic                    busy
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [TCNT_WIDTH-1:0] LAST_TOOTH =
        TCNT_WIDTH'(TOOTH_TOTAL - 1);
    localparam logic [TCNT_WIDTH-1:0] REAL_LIM =
        TCNT_WIDTH'(TOOTH_TOTAL - TOOTH_MISSING);
    localparam logic [TCNT_WIDTH-1:0] T_ONE = TCNT_WIDTH'(1);
    localparam logic [PERIOD_WIDTH-1:0] P_MIN = PERIOD_WIDTH'(4);
    localparam logic [PERIOD_WIDTH-1:0] P_ONE = PERIOD_WIDTH'(1);

    logic [0:0]              state_q, state_d;
    logic [PERIOD_WIDTH-1:0] plen_q, plen_d;
    logic [PERIOD_WIDTH-1:0] pcnt_q, pcnt_d;
    logic [TCNT_WIDTH-1:0]   tooth_q, tooth_d;
    logic                    cap_q, cap_d;
    logic                    rev_q, rev_d;

    logic [PERIOD_WIDTH-1:0] p_clamped;
    logic [PERIOD_WIDTH-1:0] half;
    logic                    slot_end;
    logic                    cam_set;
    logic                    cam_clr;
    logic                    cam_flip;

    assign p_clamped = (period < P_MIN) ? P_MIN : period;
    assign half      = plen_q >> 1;
    assign slot_end  = (pcnt_q == (plen_q - P_ONE));

    // Next-state: outputs are precomputed so every port is a flop output.
    always_comb begin
        state_d  = state_q;
        plen_d   = plen_q;
        pcnt_d   = pcnt_q;
        tooth_d  = tooth_q;
        cap_d    = cap_q;
        rev_d    = 1'b0;
        cam_set  = 1'b0;
        cam_clr  = 1'b0;
        cam_flip = 1'b0;
        case (state_q)
            S_IDLE: begin
                pcnt_d  = '0;
                tooth_d = '0;
                cap_d   = 1'b0;
                if (ena) begin
                    state_d = S_RUN;
                    plen_d  = p_clamped;
                    cap_d   = 1'b1;
                    rev_d   = 1'b1;
                    cam_set = 1'b1;
                end
            end
            S_RUN: begin
                if (!slot_end) begin
                    pcnt_d = pcnt_q + P_ONE;
                    cap_d  = (tooth_q < REAL_LIM) && (pcnt_d < half);
                end else if (!ena) begin
                    state_d = S_IDLE;
                    pcnt_d  = '0;
                    tooth_d = '0;
                    cap_d   = 1'b0;
                    cam_clr = 1'b1;
                end else begin
                    pcnt_d   = '0;
                    plen_d   = p_clamped;
                    tooth_d  = (tooth_q == LAST_TOOTH) ? '0
                                                       : tooth_q + T_ONE;
                    // Clamped period keeps half >= 2, so slot start is high.
                    cap_d    = (tooth_d < REAL_LIM);
                    rev_d    = (tooth_d == '0);
                    cam_flip = (tooth_d == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            plen_q  <= P_MIN;
            pcnt_q  <= '0;
            tooth_q <= '0;
            cap_q   <= 1'b0;
            rev_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            plen_q  <= plen_d;
            pcnt_q  <= pcnt_d;
            tooth_q <= tooth_d;
            cap_q   <= cap_d;
            rev_q   <= rev_d;
        end
    end

`ifdef CKP_GEN_CAM_EN
    logic cam_q;

    // Cam starts high on RUN entry and flips at each later slot-0 start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cam_q <= 1'b0;
        end else if (cam_set) begin
            cam_q <= 1'b1;
        end else if (cam_clr) begin
            cam_q <= 1'b0;
        end else if (cam_flip) begin
            cam_q <= ~cam_q;
        end
    end

    assign cam = cam_q;
`else
    logic unused_cam;
    assign unused_cam = ^{cam_set, cam_clr, cam_flip};
    assign cam        = 1'b0;
`endif

    assign cap        = cap_q;
    assign tooth      = tooth_q;
    assign rev_strobe = rev_q;
    assign busy       = (state_q == S_RUN);

endmodule

// File: tb/tb_ckp_gen.sv
// tb_ckp_gen: slot-level reference model feeding a per-cycle scoreboard.
// Honours CKP_GEN_CAM_EN the same way the design does.
module tb_ckp_gen;

    localparam int TT = 60;
    localparam int TM = 2;

    typedef struct packed {
        logic       cap;
        logic       cam;
        logic [5:0] tooth;
        logic       rev;
        logic       busy;
    } out_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [23:0] period;
    logic        cap;
    logic        cam;
    logic [5:0]  tooth;
    logic        rev_strobe;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    out_t exp_q[$];
    out_t slot_q[$];

    bit m_run   = 1'b0;
    bit m_cam   = 1'b0;
    int m_tooth = 0;
    int m_pos   = 0;

    ckp_gen dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .period    (period),
        .cap       (cap),
        .cam       (cam),
        .tooth     (tooth),
        .rev_strobe(rev_strobe),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Expand one whole slot of expected outputs from its period.
    function automatic void build_slot(int p_in);
        int p;
        out_t o;
        p = (p_in < 4) ? 4 : p_in;
        slot_q.delete();
        for (int i = 0; i < p; i++) begin
            o.cap   = (m_tooth < TT - TM) && (i < p / 2);
`ifdef CKP_GEN_CAM_EN
            o.cam   = m_cam;
`else
            o.cam   = 1'b0;
`endif
            o.tooth = 6'(m_tooth);
            o.rev   = (m_tooth == 0) && (i == 0);
            o.busy  = 1'b1;
            slot_q.push_back(o);
        end
    endfunction

    // Reference model: predicts the outputs visible after each edge.
    always @(posedge clk) begin
        out_t e;
        e = '0;
        if (!rst) begin
            m_run = 1'b0;
            m_cam = 1'b0;
            slot_q.delete();
        end else if (!m_run) begin
            if (ena) begin
                m_run   = 1'b1;
                m_tooth = 0;
                m_cam   = 1'b1;
                build_slot(int'(period));
                e       = slot_q.pop_front();
                m_pos   = 0;
            end
        end else if (slot_q.size() > 0) begin
            e     = slot_q.pop_front();
            m_pos = m_pos + 1;
        end else if (ena) begin
            m_tooth = (m_tooth + 1) % TT;
            if (m_tooth == 0) m_cam = !m_cam;
            build_slot(int'(period));
            e     = slot_q.pop_front();
            m_pos = 0;
        end else begin
            m_run = 1'b0;
            m_cam = 1'b0;
        end
        exp_q.push_back(e);
    end

    // Monitor: compare DUT outputs against the queued prediction.
    always @(posedge clk) begin
        out_t got;
        out_t e;
        #1;
        cyc = cyc + 1;
        got = {cap, cam, tooth, rev_strobe, busy};
        checks = checks + 1;
        if (exp_q.size() == 0) begin
            failures = failures + 1;
            $display("FAIL outputs cycle %0d: no prediction queued", cyc);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                failures = failures + 1;
                $display("FAIL outputs cycle %0d: got cap=%b cam=%b tooth=%0d rev=%b busy=%b need cap=%b cam=%b tooth=%0d rev=%b busy=%b",
                         cyc, got.cap, got.cam, got.tooth, got.rev, got.busy,
                         e.cap, e.cam, e.tooth, e.rev, e.busy);
            end
        end
    end

    // Wait (bounded) until the model is at slot t, cycle p of the slot.
    task automatic wait_pos(input int t, input int p);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < 3000 && !hit; n++) begin
            @(negedge clk);
            if (m_run && m_tooth == t && m_pos == p) hit = 1'b1;
        end
        checks = checks + 1;
        if (!hit) begin
            failures = failures + 1;
            $display("FAIL wait_pos: slot %0d pos %0d not reached, got none, need reached", t, p);
        end
    endtask

    initial begin
        rst    = 1'b0;
        ena    = 1'b0;
        period = 24'd10;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Basic run across two revolutions (cam A/B).
        ena = 1'b1;
        repeat (1300) @(negedge clk);

        // Odd period, then clamp.
        period = 24'd11;
        repeat (700) @(negedge clk);
        period = 24'd2;
        repeat (300) @(negedge clk);

        // Mid-slot period change at pcnt 3 of slot 7.
        period = 24'd10;
        wait_pos(7, 3);
        period = 24'd20;
        repeat (60) @(negedge clk);

        // Stop at pcnt 2 of slot 30.
        period = 24'd10;
        wait_pos(30, 2);
        ena = 1'b0;
        repeat (40) @(negedge clk);

        // Restart, then reset mid-slot.
        ena = 1'b1;
        repeat (53) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);

        // Brief ena glitch inside a slot must not interrupt.
        period = 24'd12;
        wait_pos(3, 1);
        ena = 1'b0;
        repeat (4) @(negedge clk);
        ena = 1'b1;
        repeat (30) @(negedge clk);

        // Randomised period, ena and reset activity.
        for (int i = 0; i < 4000; i++) begin
            rst = 1'b1;
            if ($urandom_range(0, 99) < 3)
                period = 24'($urandom_range(0, 30));
            if ($urandom_range(0, 299) == 0)
                ena = ~ena;
            if ($urandom_range(0, 1499) == 0)
                rst = 1'b0;
            @(negedge clk);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ckp_gen.md
# ckp_gen

Crankshaft position signal generator: the transmit-side counterpart of the angle generator's crank capture path. It synthesises a 60-2 toothed-wheel waveform (`cap`) and a once-per-two-revolutions phase signal (`cam`) from a programmable tooth period. It sits on the bench/HIL side of the design, driving `hwag` inputs for closed-loop verification and for stimulating an external ECU.

## Interface

Parameters:
- `TOOTH_TOTAL`, default 60: tooth slots per revolution, including missing slots.
- `TOOTH_MISSING`, default 2: missing slots at the end of each revolution.
- `PERIOD_WIDTH`, default 24: width of the tooth period, matching the capture counter width.
- `TCNT_WIDTH`, default 6: width of the slot index.

Ports (one clock; `rst` is a synchronous, active-low reset):
- `clk`, input, 1: module clock.
- `rst`, input, 1: synchronous active-low reset; 0 resets on the next `clk` edge.
- `ena`, input, 1: run request.
- `period`, input, PERIOD_WIDTH: tooth slot length in `clk` cycles.
- `cap`, output, 1: crank wheel signal.
- `cam`, output, 1: phase signal.
- `tooth`, output, TCNT_WIDTH: current slot index, 0..TOOTH_TOTAL-1.
- `rev_strobe`, output, 1: one-cycle pulse on the first cycle of slot 0.
- `busy`, output, 1: generator in RUN state.

## Operation

- State machine with two states, IDLE and RUN.
- **IDLE.** `cap`=0, `tooth`=0 and the phase counter `pcnt`=0.
  - IDLE -> RUN when `ena`=1 at an edge.
- **Slot start (RUN).** At the first cycle of every slot:
  - `period` is latched into `period_l`.
  - Values below 4 are clamped to 4.
  - `half` = `period_l`>>1.
- **Phase counter.** `pcnt` counts 0..`period_l`-1. At `pcnt`=`period_l`-1:
  - `pcnt` -> 0 and `tooth` increments.
  - `tooth` wraps TOOTH_TOTAL-1 -> 0.
- **Real slots** (`tooth` < TOOTH_TOTAL-TOOTH_MISSING):
  - `cap`=1 while `pcnt` < `half`, else 0.
  - The falling edge at mid-slot is the main edge; the receiver runs with falling-edge select.
- **Missing slots.** `cap`=0 for the whole slot.
- **`cam`.** Toggles at each slot-0 start, so it is high for revolution A and low for revolution B. It starts at 1 on the first revolution after IDLE.
- **`rev_strobe`.** Asserted in the first cycle of slot 0, including the first slot after RUN entry.
- **`ena` deasserted in RUN.** The current slot completes, then the block returns to IDLE. No runt pulses are produced.
  - If `ena` returns to 1 before the slot ends, the block continues without interruption.
- **`period` changes.** Changes take effect only at the next slot start. The within-slot waveform is never altered.

## Timing

- All outputs are flop outputs. Reset values: `cap`=0, `cam`=0, `tooth`=0, `rev_strobe`=0, `busy`=0.
- **RUN entry latency.** Edge k samples `ena`=1 in IDLE. In the cycle after edge k:
  - `busy`=1, `rev_strobe`=1, `tooth`=0, `cam`=1 and `cap`=1.
- **Real slot of length P:**
  - `cap` is high for exactly P>>1 cycles.
  - `cap` is low for P-(P>>1) cycles.
- **Revolution.** Exactly TOOTH_TOTAL×P cycles at constant P.
- **Gap length.** The low stretch after the last real tooth is (P-(P>>1)) + TOOTH_MISSING×P cycles.
- **Return to IDLE.** `busy` falls in the cycle after the last cycle of the final slot, and `cap`=0 from then on.
- **Reset dominance.** `rst`=0 mid-slot forces all reset values on the next edge, regardless of `ena`.
- **Simultaneous events.**
  - Slot end and `ena`=0 together: go to IDLE.
  - Slot end and a new `period`: the new value is latched.

## Configuration

- `CKP_GEN_CAM_EN` defined:
  - the `cam` toggle flop is built and behaves as described above.
- `CKP_GEN_CAM_EN` undefined:
  - `cam` is driven constant 0;
  - the flop is not instantiated;
  - all other behaviour is identical.

## Test plan

- **Basic run.** Reset, then `period`=10, `ena`=1.
  - Each revolution is 600 cycles, with 58 pulses of 5 cycles high and 5 cycles low.
  - The gap low stretch is 25 cycles.
  - `rev_strobe` pulses every 600 cycles.
- **Odd period and clamp.**
  - `period`=11 gives 5 cycles high and 6 cycles low per real slot.
  - `period`=2 is clamped to 4, giving 2 cycles high and 2 cycles low.
- **Mid-slot period change.** Change `period` from 10 to 20 at `pcnt`=3 of slot 7.
  - Slot 7 stays 10 cycles long.
  - Slot 8 is 20 cycles long, with 10 cycles high.
- **Stop and reset.**
  - Drop `ena` at `pcnt`=2 of slot 30: slot 30 completes, then `busy`=0 and `cap`=0.
  - Assert `rst`=0 mid-slot: all outputs are 0 on the next edge.
- **Cam (with `CKP_GEN_CAM_EN`).** With `period`=10:
  - `cam` is high for cycles 0..599 and low for cycles 600..1199, then repeats.
  - With the macro undefined, `cam` is always 0.
- **Closed loop.** Drive `cap` into `hwag` with `period`=100.
  - `hwag_start` asserts at the main edge of slot 2 of the second revolution and stays high.
  - The angle counter wraps at 3839 once per 6000 cycles.
